// File: rtl/frame_reader_pkg.sv
// Shared definitions for the SDRAM frame reader.
//   state_t / St*   : controller states (IDLE, ISSUE, WAIT, DONE)
//   SDRAM_BASE      : byte address of the frame buffer
//   FRAME_WORDS     : 32-bit words in one 640x480 frame
//   BYTES_PER_WORD  : address stride between consecutive pixel words
package frame_reader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StWait  = 2'd2;
  localparam state_t StDone  = 2'd3;

  localparam logic [31:0]  SDRAM_BASE     = 32'h0800_0000;
  localparam int unsigned  FRAME_WORDS    = 307200;
  localparam int unsigned  BYTES_PER_WORD = 4;

endpackage

// File: rtl/sdram_rd_fifo.sv
// Return-data FIFO for the frame reader.
//   clk, reset_n : clock, asynchronous active-low reset (clears pointers/count)
//   push, push_data : write one word (ignored when full)
//   pop, pop_data   : pop_data is the head word, zero when empty; pop ignored when empty
//   full, empty, count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sdram_rd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Gate the head so an empty FIFO presents zero rather than stale data.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until a push makes it valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Avalon-MM pipelined read master that fetches a contiguous run of pixel words
// and streams them out through a small FIFO, accumulating a 32-bit checksum.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : one-cycle run request, honoured only when idle
//   base_addr, word_count : run parameters, sampled on an accepted start
//   busy, done            : run in progress / one-cycle completion pulse
//   checksum              : sum mod 2^DATAWIDTH of the words returned this run
//   master_*              : Avalon-MM read master (address, read, waitrequest,
//                           readdata, readdatavalid)
//   out_data/valid/ready  : valid/ready output stream (FIFO head)
module sdram_frame_reader
  import frame_reader_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH    = 26,
  parameter int unsigned DATAWIDTH       = 32,
  parameter int unsigned LENWIDTH        = 20,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDRESSWIDTH-1:0] base_addr,
  input  logic [LENWIDTH-1:0]     word_count,
  output logic                    busy,
  output logic                    done,
  output logic [DATAWIDTH-1:0]    checksum,
  output logic [ADDRESSWIDTH-1:0] master_address,
  output logic                    master_read,
  input  logic                    master_waitrequest,
  input  logic [DATAWIDTH-1:0]    master_readdata,
  input  logic                    master_readdatavalid,
  output logic [DATAWIDTH-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] base_q, base_d;
  logic [LENWIDTH-1:0]     count_q, count_d;
  logic [LENWIDTH-1:0]     issued_q, issued_d;
  logic [LENWIDTH-1:0]     received_q, received_d;
  logic [OW-1:0]           outstanding_q, outstanding_d;
  logic [DATAWIDTH-1:0]    checksum_q, checksum_d;
  logic                    read_q, read_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;

  logic                    rd_accept, rv_take, pop_take, fifo_push;
  logic                    fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count, fifo_cnt_next;
  logic [31:0]             credit_next;

  assign rd_accept = read_q && !master_waitrequest;
  // Returns seen while idle belong to a run that was aborted by reset.
  assign rv_take   = master_readdatavalid && (state_q != StIdle);
  assign fifo_push = rv_take && !fifo_full;
  assign pop_take  = out_valid && out_ready;

  assign fifo_cnt_next = fifo_count + CW'(fifo_push) - CW'(pop_take);

  sdram_rd_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (master_readdata),
    .pop       (pop_take),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state counters and FSM.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    checksum_d    = checksum_q;

    if (rd_accept) issued_d = issued_q + LENWIDTH'(1);

    if (rd_accept && !rv_take) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (!rd_accept && rv_take) begin
      outstanding_d = outstanding_q - OW'(1);
    end

    if (rv_take) begin
      received_d = received_q + LENWIDTH'(1);
      checksum_d = checksum_q + master_readdata;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          base_d        = {base_addr[ADDRESSWIDTH-1:2], 2'b00};
          count_d       = word_count;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          checksum_d    = '0;
          state_d       = (word_count == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (issued_d == count_q) state_d = StWait;
      end
      StWait: begin
        if ((received_q == count_q) && fifo_empty) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // The read request is registered, so its qualification is evaluated against
  // next-cycle counts. While the request waits, outstanding+fifo_count can only
  // shrink, so a held request stays within the credit limit.
  always_comb begin
    credit_next = 32'(outstanding_d) + 32'(fifo_cnt_next);
    read_d      = 1'b0;
    addr_d      = addr_q;
    if (read_q && master_waitrequest) begin
      read_d = 1'b1;
    end else begin
      read_d = (state_d == StIssue) && (issued_d < count_d) &&
               (outstanding_d < OW'(MAX_OUTSTANDING)) && (credit_next < FIFO_DEPTH);
      if (read_d) begin
        addr_d = base_d + ADDRESSWIDTH'(issued_d) * ADDRESSWIDTH'(BYTES_PER_WORD);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      base_q        <= '0;
      count_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      checksum_q    <= '0;
      read_q        <= 1'b0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      checksum_q    <= checksum_d;
      read_q        <= read_d;
      addr_q        <= addr_d;
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign checksum       = checksum_q;
  assign master_read    = read_q;
  assign master_address = addr_q;
  assign out_valid      = !fifo_empty;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Scoreboard bench for sdram_frame_reader. A behavioural Avalon slave returns
// word (addr - SDRAM_BASE)/4 + 1 after a programmable latency and can stall one
// chosen read. Expected addresses and stream words are queued by the stimulus;
// the slave and the stream monitor pop and compare independently.
module tb_sdram_frame_reader;
  import frame_reader_pkg::*;

  // 32-bit addressing so the 0x0800_0000 frame base is representable.
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] word_count = '0;
  logic          busy, done;
  logic [DW-1:0] checksum;
  logic [AW-1:0] master_address;
  logic          master_read;
  logic          master_waitrequest = 1'b0;
  logic [DW-1:0] master_readdata = '0;
  logic          master_readdatavalid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  sdram_frame_reader #(
    .ADDRESSWIDTH    (AW),
    .DATAWIDTH       (DW),
    .LENWIDTH        (LW),
    .FIFO_DEPTH      (8),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .base_addr            (base_addr),
    .word_count           (word_count),
    .busy                 (busy),
    .done                 (done),
    .checksum             (checksum),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .out_data             (out_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];

  // Slave model state
  int            lat = 2;
  int            stall_idx = -1;
  int            stall_left = 0;
  int            reads_seen = 0;
  int            reads_presented = 0;
  int            hold_cycles = 0;
  int            hold_of_idx1 = 0;
  int            tb_out = 0;
  int            max_out = 0;
  int            cyc = 0;
  int            first_acc = -1;
  int            last_acc = -1;
  int            done_cnt = 0;
  logic          done_prev = 1'b0;
  logic          pipe_v[16];
  logic [AW-1:0] pipe_a[16];
  logic          slv_acc, slv_del;
  logic [AW-1:0] slv_a;
  logic [DW-1:0] mon_d;

  initial begin
    for (int i = 0; i < 16; i++) begin
      pipe_v[i] = 1'b0;
      pipe_a[i] = '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Avalon slave: decides waitrequest, checks accepted addresses, returns data.
  always @(negedge clk) begin
    cyc++;
    master_waitrequest = 1'b0;
    if (master_read) begin
      reads_presented++;
      hold_cycles++;
      if (reads_seen == stall_idx && stall_left > 0) begin
        master_waitrequest = 1'b1;
        stall_left--;
      end
    end
    slv_acc = master_read && !master_waitrequest;
    if (slv_acc) begin
      if (reads_seen == 1) hold_of_idx1 = hold_cycles;
      hold_cycles = 0;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (exp_addr_q.size() == 0) begin
        check("unexpected read", {32'd0, master_address}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        slv_a = exp_addr_q.pop_front();
        check("read address", {32'd0, master_address}, {32'd0, slv_a});
      end
      reads_seen++;
    end
    for (int i = 15; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_a[i] = pipe_a[i-1];
    end
    pipe_v[0] = slv_acc;
    pipe_a[0] = master_address;
    slv_del = pipe_v[lat];
    master_readdatavalid = slv_del;
    master_readdata = slv_del ? (((pipe_a[lat] - SDRAM_BASE) >> 2) + 32'd1) : 32'hDEAD_BEEF;
    tb_out = tb_out + int'(slv_acc) - int'(slv_del);
    if (tb_out > max_out) max_out = tb_out;
  end

  // Stream scoreboard and done/busy monitor.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected stream word", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else if (out_ready) begin
        mon_d = exp_data_q.pop_front();
        check("stream data", {32'd0, out_data}, {32'd0, mon_d});
      end
    end
    if (done) done_cnt++;
    if (done_prev) check("busy after done", {63'd0, busy}, 64'd0);
    done_prev = done;
  end

  task automatic setup(input int l, input int sidx, input int slen);
    lat             = l;
    stall_idx       = sidx;
    stall_left      = slen;
    reads_seen      = 0;
    reads_presented = 0;
    hold_cycles     = 0;
    hold_of_idx1    = 0;
    max_out         = 0;
    first_acc       = -1;
    last_acc        = -1;
  endtask

  task automatic push_expected(input logic [AW-1:0] base, input int n, input bit with_data);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(base + AW'(4 * i));
      if (with_data) exp_data_q.push_back(DW'(i + 1));
    end
  endtask

  // Returns #1 after the edge that accepts start.
  task automatic pulse_start(input logic [AW-1:0] base, input logic [LW-1:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check({"timeout ", name}, 64'd0, 64'd1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, {63'd0, busy}, 64'd0);
    check({tag, " done"}, {63'd0, done}, 64'd0);
    check({tag, " master_read"}, {63'd0, master_read}, 64'd0);
    check({tag, " master_address"}, {32'd0, master_address}, 64'd0);
    check({tag, " out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, " out_data"}, {32'd0, out_data}, 64'd0);
    check({tag, " checksum"}, {32'd0, checksum}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    settle(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    settle(2);

    // 1: four words, no stalls, 2-cycle latency
    setup(2, -1, 0);
    d0 = done_cnt;
    push_expected(SDRAM_BASE, 4, 1'b1);
    pulse_start(SDRAM_BASE, 4);
    check("t1 busy after start", {63'd0, busy}, 64'd1);
    check("t1 first read", {63'd0, master_read}, 64'd1);
    check("t1 first address", {32'd0, master_address}, 64'h0800_0000);
    wait_done(100, "t1");
    check("t1 checksum", {32'd0, checksum}, 64'd10);
    settle(3);
    check("t1 reads accepted", 64'(reads_seen), 64'd4);
    check("t1 back-to-back", 64'(last_acc - first_acc), 64'd3);
    check("t1 done pulses", 64'(done_cnt - d0), 64'd1);
    check("t1 stream drained", 64'(exp_data_q.size()), 64'd0);

    // 2: second read stalled for three cycles
    setup(2, 1, 3);
    d0 = done_cnt;
    push_expected(SDRAM_BASE, 4, 1'b1);
    pulse_start(SDRAM_BASE, 4);
    wait_done(100, "t2");
    check("t2 checksum", {32'd0, checksum}, 64'd10);
    settle(3);
    check("t2 reads accepted", 64'(reads_seen), 64'd4);
    check("t2 read cycles", 64'(reads_presented), 64'd7);
    check("t2 addr hold cycles", 64'(hold_of_idx1), 64'd4);
    check("t2 done pulses", 64'(done_cnt - d0), 64'd1);

    // 3: sixteen words with the stream blocked for the first 20 cycles
    setup(2, -1, 0);
    d0 = done_cnt;
    out_ready = 1'b0;
    push_expected(SDRAM_BASE, 16, 1'b1);
    pulse_start(SDRAM_BASE, 16);
    settle(19);
    check("t3 reads before release", 64'(reads_seen), 64'd8);
    check("t3 out_valid while blocked", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    wait_done(300, "t3");
    check("t3 checksum", {32'd0, checksum}, 64'd136);
    settle(3);
    check("t3 reads accepted", 64'(reads_seen), 64'd16);
    check("t3 outstanding bound", {63'd0, max_out <= 4}, 64'd1);
    check("t3 stream drained", 64'(exp_data_q.size()), 64'd0);
    check("t3 done pulses", 64'(done_cnt - d0), 64'd1);

    // 4: zero-length run
    setup(2, -1, 0);
    d0 = done_cnt;
    pulse_start(SDRAM_BASE, 0);
    check("t4 busy", {63'd0, busy}, 64'd1);
    check("t4 done", {63'd0, done}, 64'd1);
    settle(1);
    check("t4 busy after", {63'd0, busy}, 64'd0);
    settle(3);
    check("t4 reads presented", 64'(reads_presented), 64'd0);
    check("t4 checksum", {32'd0, checksum}, 64'd0);
    check("t4 done pulses", 64'(done_cnt - d0), 64'd1);

    // 5: second start mid-run is ignored
    setup(2, -1, 0);
    d0 = done_cnt;
    push_expected(SDRAM_BASE, 4, 1'b1);
    pulse_start(SDRAM_BASE, 4);
    start = 1'b1; base_addr = SDRAM_BASE + 32'h100; word_count = 9;
    settle(1);
    start = 1'b0;
    wait_done(100, "t5");
    check("t5 checksum", {32'd0, checksum}, 64'd10);
    settle(4);
    check("t5 reads accepted", 64'(reads_seen), 64'd4);
    check("t5 busy idle", {63'd0, busy}, 64'd0);
    check("t5 done pulses", 64'(done_cnt - d0), 64'd1);

    // 6: reset with three reads outstanding; returns land after reset
    setup(6, -1, 0);
    push_expected(SDRAM_BASE, 16, 1'b0);
    pulse_start(SDRAM_BASE, 16);
    for (int i = 0; i < 40 && tb_out != 3; i++) settle(1);
    check("t6 outstanding at reset", 64'(tb_out), 64'd3);
    reset_n = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    d0 = done_cnt;
    #1;
    check_reset_outputs("t6 in reset");
    settle(1);
    reset_n = 1'b1;
    settle(12);
    check("t6 late returns drained", 64'(tb_out), 64'd0);
    check("t6 no done", 64'(done_cnt - d0), 64'd0);
    check("t6 checksum", {32'd0, checksum}, 64'd0);
    check("t6 busy", {63'd0, busy}, 64'd0);
    check("t6 out_valid", {63'd0, out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
